// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the M stage.
// Owns SR/Cause/EPC, raises the flush/redirect request and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = 32'h2023_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im_r;
    logic        sr_exl_r;
    logic        sr_ie_r;
    logic        cause_bd_r;
    logic [5:0]  cause_ip_r;
    logic [4:0]  cause_exc_r;
    logic [31:0] epc_r;

    logic [5:0]  sr_im_s;
    logic        sr_exl_s;
    logic        sr_ie_s;
    logic        cause_bd_s;
    logic [5:0]  cause_ip_s;
    logic [4:0]  cause_exc_s;
    logic [31:0] epc_s;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic [31:0] epc_victim_s;
    logic [31:0] sr_word_s;
    logic [31:0] cause_word_s;

    // Request decision; EXL masks both sources so nested events are dropped.
    always_comb begin
        int_req_s    = (|(hw_int & sr_im_r)) & sr_ie_r & ~sr_exl_r;
        exc_req_s    = (exc_code_in != 5'd0) & ~sr_exl_r;
        req_s        = int_req_s | exc_req_s;
        // A delay-slot victim restarts at its branch, one word earlier.
        epc_victim_s = (bd_in ? (vpc - 32'd4) : vpc) & 32'hFFFF_FFFC;
    end

    // Next-state for CP0 registers: a taken request beats mtc0 and eret.
    always_comb begin
        sr_im_s     = sr_im_r;
        sr_exl_s    = sr_exl_r;
        sr_ie_s     = sr_ie_r;
        cause_bd_s  = cause_bd_r;
        cause_exc_s = cause_exc_r;
        epc_s       = epc_r;
        cause_ip_s  = hw_int;
        if (req_s) begin
            sr_exl_s    = 1'b1;
            cause_exc_s = int_req_s ? 5'd0 : exc_code_in;
            cause_bd_s  = bd_in;
            epc_s       = epc_victim_s;
        end else begin
            if (we && (cp0_addr == ADDR_SR)) begin
                sr_im_s  = cp0_in[15:10];
                sr_exl_s = cp0_in[1];
                sr_ie_s  = cp0_in[0];
            end else if (we && (cp0_addr == ADDR_EPC)) begin
                epc_s = cp0_in;
            end else begin
                epc_s = epc_r;
            end
            // eret's clear overrides an EXL bit written by a concurrent mtc0.
            if (eret) begin
                sr_exl_s = 1'b0;
            end else begin
                sr_exl_s = sr_exl_s;
            end
        end
    end

    // CP0 state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_r     <= 6'd0;
            sr_exl_r    <= 1'b0;
            sr_ie_r     <= 1'b0;
            cause_bd_r  <= 1'b0;
            cause_ip_r  <= 6'd0;
            cause_exc_r <= 5'd0;
            epc_r       <= 32'd0;
        end else begin
            sr_im_r     <= sr_im_s;
            sr_exl_r    <= sr_exl_s;
            sr_ie_r     <= sr_ie_s;
            cause_bd_r  <= cause_bd_s;
            cause_ip_r  <= cause_ip_s;
            cause_exc_r <= cause_exc_s;
            epc_r       <= epc_s;
        end
    end

    // mfc0 read mux; unimplemented bits and addresses read as zero.
    always_comb begin
        sr_word_s    = {16'd0, sr_im_r, 8'd0, sr_exl_r, sr_ie_r};
        cause_word_s = {cause_bd_r, 15'd0, cause_ip_r, 3'd0, cause_exc_r, 2'd0};
        case (cp0_addr)
            ADDR_SR:    cp0_out = sr_word_s;
            ADDR_CAUSE: cp0_out = cause_word_s;
            ADDR_EPC:   cp0_out = epc_r;
            ADDR_PRID:  cp0_out = PRID;
            default:    cp0_out = 32'd0;
        endcase
    end

    assign req        = req_s;
    assign epc_out    = epc_r;
    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized plus directed bench for cp0_exc_ctrl, using a scoreboard queue
// filled from a word-level CP0 model and drained by an independent monitor.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID       = 32'h2023_0007;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .eret(eret), .req(req), .epc_out(epc_out),
        .handler_pc(handler_pc)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cycle_no = 0;

    // Reference state kept as the architecturally visible 32-bit words.
    logic [31:0] sr_m, cause_m, epc_m;

    function automatic logic [31:0] rd_m(input logic [4:0] a);
        case (a)
            5'd12:   return sr_m;
            5'd13:   return cause_m;
            5'd14:   return epc_m;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic int_m();
        return ((hw_int & sr_m[15:10]) != 6'd0) && sr_m[0] && !sr_m[1];
    endfunction

    function automatic logic exc_m();
        return (exc_code_in != 5'd0) && !sr_m[1];
    endfunction

    task automatic update_m();
        logic ir, er, take;
        logic [31:0] tgt;
        ir   = int_m();
        er   = exc_m();
        take = ir || er;
        cause_m[15:10] = hw_int;
        if (take) begin
            sr_m[1]       = 1'b1;
            cause_m[6:2]  = ir ? 5'd0 : exc_code_in;
            cause_m[31]   = bd_in;
            tgt           = bd_in ? vpc - 32'd4 : vpc;
            epc_m         = {tgt[31:2], 2'b00};
        end else begin
            if (we && cp0_addr == 5'd12) sr_m = cp0_in & 32'h0000_FC03;
            if (we && cp0_addr == 5'd14) epc_m = cp0_in;
            if (eret) sr_m[1] = 1'b0;
        end
    endtask

    task automatic cyc(input logic rst, input logic w, input logic [4:0] a,
                       input logic [31:0] din, input logic [31:0] pc, input logic bd,
                       input logic [4:0] ec, input logic [5:0] hw, input logic er);
        exp_t e;
        @(negedge clk);
        reset = rst; we = w; cp0_addr = a; cp0_in = din; vpc = pc;
        bd_in = bd; exc_code_in = ec; hw_int = hw; eret = er;
        if (!rst) begin
            sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;
        end
        #1;
        e.cyc  = cycle_no;
        e.addr = a;
        e.req  = int_m() || exc_m();
        e.rd   = rd_m(a);
        e.epc  = epc_m;
        q.push_back(e);
        cycle_no++;
        @(posedge clk);
        if (rst) update_m();
    endtask

    // Monitor: drains the scoreboard mid-cycle, after the driver has settled inputs.
    always @(negedge clk) begin
        exp_t e;
        #2;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (req !== e.req) begin
                errors++;
                $display("FAIL req cyc=%0d: got %b expected %b", e.cyc, req, e.req);
            end
            checks++;
            if (cp0_out !== e.rd) begin
                errors++;
                $display("FAIL cp0_out[%0d] cyc=%0d: got %h expected %h", e.addr, e.cyc, cp0_out, e.rd);
            end
            checks++;
            if (epc_out !== e.epc) begin
                errors++;
                $display("FAIL epc_out cyc=%0d: got %h expected %h", e.cyc, epc_out, e.epc);
            end
            checks++;
            if (handler_pc !== HANDLER_PC) begin
                errors++;
                $display("FAIL handler_pc cyc=%0d: got %h expected %h", e.cyc, handler_pc, HANDLER_PC);
            end
        end
    end

    initial begin
        logic [4:0] ra;
        reset = 1'b0; we = 1'b0; cp0_addr = 5'd0; cp0_in = 32'd0; vpc = 32'd0;
        bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
        sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;

        cyc(0, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 13, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 0);
        // AdEL with SR = 0x401
        cyc(1, 1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 13, 0, 32'h0000_3010, 0, 5'd4, 0, 0);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 13, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        // delay-slot AdES
        cyc(1, 0, 13, 0, 32'h0000_3024, 1, 5'd5, 0, 0);
        cyc(1, 0, 13, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 1);
        // interrupt beats exception
        cyc(1, 0, 13, 0, 32'h0000_5000, 0, 5'd4, 6'b000001, 0);
        cyc(1, 0, 13, 0, 0, 0, 0, 6'b000001, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 1);
        // masked: IE=0, then EXL=1
        cyc(1, 1, 12, 32'h0000_FC00, 0, 0, 0, 0, 0);
        cyc(1, 0, 13, 0, 0, 0, 0, 6'h3f, 0);
        cyc(1, 0, 13, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 12, 32'h0000_FC03, 0, 0, 0, 0, 0);
        cyc(1, 0, 12, 0, 32'h0000_6000, 0, 5'd4, 6'h3f, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 0);
        // mtc0 EPC, eret, then write discarded by a concurrent request
        cyc(1, 1, 14, 32'h0000_3100, 0, 0, 0, 0, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 12, 32'h0000_0002, 0, 0, 0, 6'b000001, 0);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        // eret together with mtc0 SR
        cyc(1, 1, 12, 32'h0000_0407, 0, 0, 0, 0, 1);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        // vpc wrap in a delay slot
        cyc(1, 0, 14, 0, 32'h0000_0000, 1, 5'd4, 0, 0);
        cyc(1, 0, 14, 0, 0, 0, 0, 0, 0);
        // asynchronous reset mid-run
        cyc(1, 1, 12, 32'h0000_FC03, 0, 0, 0, 0, 0);
        cyc(1, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 13, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 14, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 15, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 3, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(5, 0))
                0:       ra = 5'd12;
                1:       ra = 5'd13;
                2:       ra = 5'd14;
                3:       ra = 5'd15;
                default: ra = 5'($urandom_range(31, 0));
            endcase
            cyc(($urandom_range(150, 0) != 0),
                ($urandom_range(3, 0) == 0),
                ra,
                $urandom,
                $urandom,
                1'($urandom_range(1, 0)),
                ($urandom_range(2, 0) == 0) ? 5'($urandom_range(31, 0)) : 5'd0,
                ($urandom_range(3, 0) == 0) ? 6'($urandom_range(63, 0)) : 6'd0,
                ($urandom_range(5, 0) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
